// File: rtl/mcp4921_spi_s_axis.sv
// -----------------------------------------------------------------------------
// mcp4921_spi_s_axis
//
// Accepts 12-bit DAC samples on an AXI4-Stream slave port and transmits each
// one to an MCP4921 DAC as a 16-bit SPI mode 0,0 frame, MSB first:
//     {1'b0, BUF, GA_N, SHDN_N, code[11:0]}
// After each frame, chip select is held high for TCSH_CLKS cycles. If the
// macro MCP4921_LDAC_EN is defined, an LDAC strobe follows: ldac_n is driven
// low for 2*TCSH_CLKS cycles. Otherwise the DAC latches on the rising edge of
// cs (LDAC is tied low on the board).
//
// Optional feature macro: MCP4921_LDAC_EN (adds the ldac_n port and the LATCH
// phase).
//
// Parameters
//   FCLK       system clock frequency in Hz (informational only)
//   HALF_DIV   clk cycles per SCK half-period (2..1023)
//   TCSH_CLKS  clk cycles cs stays high after each frame (2..255)
//   BUF        VREF buffer bit (command bit 14)
//   GA_N       gain bit, 1 = 1x (command bit 13)
//   SHDN_N     active-mode bit (command bit 12)
//
// Ports
//   clk                 system clock
//   rst                 synchronous, active-high reset
//   s_axis_dac_tdata    [11:0] unsigned DAC code; [15:12] ignored
//   s_axis_dac_tvalid   sample valid
//   s_axis_dac_tready   high only while idle and able to accept a sample
//   cs                  active-low DAC chip select
//   sck                 SPI clock, idles low
//   mosi                serial data to the DAC
//   ldac_n              DAC latch strobe (MCP4921_LDAC_EN builds only)
//
// Every output comes straight from a flop; there is no combinational path
// from tvalid or tdata to any output.
// -----------------------------------------------------------------------------
module mcp4921_spi_s_axis #(
    parameter real FCLK      = 100e6,
    parameter int  HALF_DIV  = 50,
    parameter int  TCSH_CLKS = 5,
    parameter bit  BUF       = 1'b0,
    parameter bit  GA_N      = 1'b1,
    parameter bit  SHDN_N    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] s_axis_dac_tdata,
    input  logic        s_axis_dac_tvalid,
    output logic        s_axis_dac_tready,
    output logic        cs,
    output logic        sck,
`ifdef MCP4921_LDAC_EN
    output logic        ldac_n,
`endif
    output logic        mosi
);

    // FCLK only documents the intended clock rate.
    localparam real unused_fclk_hz = FCLK;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_CSH   = 2'd2;
`ifdef MCP4921_LDAC_EN
    localparam logic [1:0] ST_LATCH = 2'd3;
    localparam logic [8:0] LATCH_LAST = 9'(2 * TCSH_CLKS - 1);
`endif

    localparam logic [9:0] HALF_LAST = 10'(HALF_DIV - 1);
    localparam logic [8:0] CSH_LAST  = 9'(TCSH_CLKS - 1);
    localparam logic [3:0] BIT_LAST  = 4'd15;

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic [9:0]  div_cnt_r;
    logic [9:0]  div_cnt_nxt_s;
    logic [3:0]  bit_cnt_r;
    logic [3:0]  bit_cnt_nxt_s;
    logic [8:0]  hold_cnt_r;
    logic [8:0]  hold_cnt_nxt_s;
    // Holds the bits still to be sent; the bit currently on mosi lives in mosi_r.
    logic [14:0] shreg_r;
    logic [14:0] shreg_nxt_s;
    logic        cs_r;
    logic        cs_nxt_s;
    logic        sck_r;
    logic        sck_nxt_s;
    logic        mosi_r;
    logic        mosi_nxt_s;
    logic        tready_r;
    logic        tready_nxt_s;
`ifdef MCP4921_LDAC_EN
    logic        ldac_r;
    logic        ldac_nxt_s;
    logic        latch_done_s;
`endif

    logic [15:0] word_s;
    logic        xfer_s;
    logic        half_done_s;
    logic        frame_end_s;
    logic        csh_done_s;
    logic        unused_s;

    assign unused_s    = ^s_axis_dac_tdata[15:12];
    assign word_s      = {1'b0, BUF, GA_N, SHDN_N, s_axis_dac_tdata[11:0]};
    assign xfer_s      = s_axis_dac_tvalid & tready_r;
    assign half_done_s = (div_cnt_r == HALF_LAST);
    // The frame ends at the falling edge that would follow the 16th bit.
    assign frame_end_s = half_done_s & sck_r & (bit_cnt_r == BIT_LAST);
    assign csh_done_s  = (hold_cnt_r == CSH_LAST);
`ifdef MCP4921_LDAC_EN
    assign latch_done_s = (hold_cnt_r == LATCH_LAST);
`endif

    // State, counter, shift and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            div_cnt_r  <= 10'd0;
            bit_cnt_r  <= 4'd0;
            hold_cnt_r <= 9'd0;
            shreg_r    <= 15'd0;
            cs_r       <= 1'b1;
            sck_r      <= 1'b0;
            mosi_r     <= 1'b0;
            tready_r   <= 1'b0;
`ifdef MCP4921_LDAC_EN
            ldac_r     <= 1'b1;
`endif
        end else begin
            state_r    <= state_nxt_s;
            div_cnt_r  <= div_cnt_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            hold_cnt_r <= hold_cnt_nxt_s;
            shreg_r    <= shreg_nxt_s;
            cs_r       <= cs_nxt_s;
            sck_r      <= sck_nxt_s;
            mosi_r     <= mosi_nxt_s;
            tready_r   <= tready_nxt_s;
`ifdef MCP4921_LDAC_EN
            ldac_r     <= ldac_nxt_s;
`endif
        end
    end

    // Next-state selection; unused encodings fall back to IDLE.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (xfer_s) begin
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (frame_end_s) begin
                    state_nxt_s = ST_CSH;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_CSH: begin
                if (csh_done_s) begin
`ifdef MCP4921_LDAC_EN
                    state_nxt_s = ST_LATCH;
`else
                    state_nxt_s = ST_IDLE;
`endif
                end else begin
                    state_nxt_s = ST_CSH;
                end
            end
`ifdef MCP4921_LDAC_EN
            ST_LATCH: begin
                if (latch_done_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_LATCH;
                end
            end
`endif
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Next values for the counters, shift register and registered outputs.
    always_comb begin
        div_cnt_nxt_s  = 10'd0;
        bit_cnt_nxt_s  = 4'd0;
        hold_cnt_nxt_s = 9'd0;
        shreg_nxt_s    = shreg_r;
        sck_nxt_s      = 1'b0;
        mosi_nxt_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (xfer_s) begin
                    shreg_nxt_s = word_s[14:0];
                    mosi_nxt_s  = word_s[15];
                end else begin
                    shreg_nxt_s = shreg_r;
                end
            end
            ST_SHIFT: begin
                if (frame_end_s) begin
                    // Close the frame: sck, mosi and counters return to zero.
                    shreg_nxt_s = 15'd0;
                end else if (half_done_s) begin
                    sck_nxt_s = ~sck_r;
                    if (sck_r) begin
                        // Falling sck edge is the only place mosi advances.
                        bit_cnt_nxt_s = bit_cnt_r + 4'd1;
                        mosi_nxt_s    = shreg_r[14];
                        shreg_nxt_s   = {shreg_r[13:0], 1'b0};
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r;
                        mosi_nxt_s    = mosi_r;
                    end
                end else begin
                    div_cnt_nxt_s = div_cnt_r + 10'd1;
                    bit_cnt_nxt_s = bit_cnt_r;
                    sck_nxt_s     = sck_r;
                    mosi_nxt_s    = mosi_r;
                end
            end
            ST_CSH: begin
                if (csh_done_s) begin
                    hold_cnt_nxt_s = 9'd0;
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r + 9'd1;
                end
            end
`ifdef MCP4921_LDAC_EN
            ST_LATCH: begin
                if (latch_done_s) begin
                    hold_cnt_nxt_s = 9'd0;
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r + 9'd1;
                end
            end
`endif
            default: begin
                shreg_nxt_s = 15'd0;
            end
        endcase

        // Framing outputs follow the state being entered, so they change on
        // the same edge as the state.
        cs_nxt_s     = (state_nxt_s != ST_SHIFT);
        tready_nxt_s = (state_nxt_s == ST_IDLE);
`ifdef MCP4921_LDAC_EN
        ldac_nxt_s   = (state_nxt_s != ST_LATCH);
`endif
    end

    assign s_axis_dac_tready = tready_r;
    assign cs                = cs_r;
    assign sck               = sck_r;
    assign mosi              = mosi_r;
`ifdef MCP4921_LDAC_EN
    assign ldac_n            = ldac_r;
`endif

endmodule

// File: tb/tb_mcp4921_spi_s_axis.sv
// -----------------------------------------------------------------------------
// Bench for mcp4921_spi_s_axis. Two instances:
//   dut 0: HALF_DIV=2, TCSH_CLKS=2, BUF=0, GA_N=1, SHDN_N=1
//   dut 1: HALF_DIV=3, TCSH_CLKS=3, BUF=1, GA_N=0, SHDN_N=1
// The reference model describes each frame as a function of the cycles elapsed
// since the accepting edge. Directed scenarios pin exact words and timings, and
// a randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_mcp4921_spi_s_axis;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  tvalid_v = 2'b00;
    logic [15:0] tdata_v [2];
    logic [1:0]  rdy_v, cs_v, sck_v, mosi_v, ldac_v;

    always #5 clk = ~clk;

    mcp4921_spi_s_axis #(
        .FCLK(100e6), .HALF_DIV(2), .TCSH_CLKS(2),
        .BUF(1'b0), .GA_N(1'b1), .SHDN_N(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst),
        .s_axis_dac_tdata(tdata_v[0]), .s_axis_dac_tvalid(tvalid_v[0]),
        .s_axis_dac_tready(rdy_v[0]),
        .cs(cs_v[0]), .sck(sck_v[0]),
`ifdef MCP4921_LDAC_EN
        .ldac_n(ldac_v[0]),
`endif
        .mosi(mosi_v[0])
    );

    mcp4921_spi_s_axis #(
        .FCLK(100e6), .HALF_DIV(3), .TCSH_CLKS(3),
        .BUF(1'b1), .GA_N(1'b0), .SHDN_N(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst),
        .s_axis_dac_tdata(tdata_v[1]), .s_axis_dac_tvalid(tvalid_v[1]),
        .s_axis_dac_tready(rdy_v[1]),
        .cs(cs_v[1]), .sck(sck_v[1]),
`ifdef MCP4921_LDAC_EN
        .ldac_n(ldac_v[1]),
`endif
        .mosi(mosi_v[1])
    );

`ifndef MCP4921_LDAC_EN
    assign ldac_v = 2'b11;
`endif

    // ---------------- per-instance configuration ----------------
    function automatic int hd(input int i);
        return (i == 0) ? 2 : 3;
    endfunction
    function automatic int tcsh(input int i);
        return (i == 0) ? 2 : 3;
    endfunction
    function automatic int flen(input int i);
`ifdef MCP4921_LDAC_EN
        return 32 * hd(i) + 3 * tcsh(i);
`else
        return 32 * hd(i) + tcsh(i);
`endif
    endfunction
    function automatic logic [3:0] cmd_bits(input int i);
        return (i == 0) ? 4'b0011 : 4'b0101;
    endfunction

    // ---------------- reference model ----------------
    // m_e counts cycles since the accepting edge; the frame occupies m_e in
    // 0 .. flen-1 and the block is idle again on the following edge.
    logic [1:0]  m_act = 2'b00;
    logic [1:0]  m_rdy = 2'b00;
    int          m_e [2];
    logic [15:0] m_word [2];

    // Advance the reference model on each clock edge.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_act[i] <= 1'b0; m_rdy[i] <= 1'b0; m_e[i] <= 0;
            end else if (m_act[i]) begin
                if (m_e[i] == flen(i) - 1) begin
                    m_act[i] <= 1'b0; m_rdy[i] <= 1'b1; m_e[i] <= 0;
                end else begin
                    m_e[i] <= m_e[i] + 1;
                end
            end else if (m_rdy[i] && tvalid_v[i]) begin
                m_act[i]  <= 1'b1; m_rdy[i] <= 1'b0; m_e[i] <= 0;
                m_word[i] <= {cmd_bits(i), tdata_v[i][11:0]};
            end else begin
                m_rdy[i] <= 1'b1;
            end
        end
    end

    // Expected {cs, sck, mosi, tready, ldac_n} from the model.
    function automatic logic [4:0] expect_out(input int i);
        int e;
        int bi;
        e = m_e[i];
        if (!m_act[i]) return {1'b1, 1'b0, 1'b0, m_rdy[i], 1'b1};
        if (e < 32 * hd(i)) begin
            bi = e / (2 * hd(i));
            return {1'b0, ((e % (2 * hd(i))) >= hd(i)), m_word[i][15 - bi], 1'b0, 1'b1};
        end
`ifdef MCP4921_LDAC_EN
        if (e >= 32 * hd(i) + tcsh(i)) return 5'b10000;
`endif
        return 5'b10001;
    endfunction

    // ---------------- waveform monitor ----------------
    logic [15:0] acc [2];
    logic [15:0] last_word [2];
    int rises[2], cslow[2], frames[2], last_rises[2], last_cslow[2];
    int highrun[2], last_high[2], rdy_cnt[2];
    logic [1:0] cs_p = 2'b11;
    logic [1:0] sck_p = 2'b00;

    // Capture the MOSI word on sck rises and measure cs low/high run lengths.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (cs_v[i] && !cs_p[i]) begin
                frames[i]     <= frames[i] + 1;
                last_word[i]  <= acc[i];
                last_rises[i] <= rises[i];
                last_cslow[i] <= cslow[i];
                acc[i] <= 16'h0000; rises[i] <= 0; cslow[i] <= 0; highrun[i] <= 1;
            end else if (cs_v[i]) begin
                highrun[i] <= highrun[i] + 1;
            end else begin
                cslow[i] <= cslow[i] + 1;
                if (cs_p[i]) last_high[i] <= highrun[i];
                if (sck_v[i] && !sck_p[i]) begin
                    acc[i]   <= {acc[i][14:0], mosi_v[i]};
                    rises[i] <= rises[i] + 1;
                end
            end
            if (rdy_v[i]) rdy_cnt[i] <= rdy_cnt[i] + 1;
        end
        cs_p  <= cs_v;
        sck_p <= sck_v;
    end

    // ---------------- checking helpers ----------------
    int n_total = 0;
    int n_pass  = 0;
    bit done    = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input int i, input logic [15:0] d);
        int n;
        n = 0;
        tdata_v[i]  = d;
        tvalid_v[i] = 1'b1;
        while (rdy_v[i] !== 1'b1 && n < 2000) begin tick(); n++; end
        check($sformatf("send%0d_accept", i), {31'd0, rdy_v[i]}, 32'd1);
        tick();
        tvalid_v[i] = 1'b0;
    endtask

    task automatic wait_frames(input int i, input int target);
        int n;
        n = 0;
        while (frames[i] < target && n < 2000) begin tick(); n++; end
        check($sformatf("frame%0d_done", i), {31'd0, (frames[i] >= target)}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, r0, n, k;
        tdata_v[0] = 16'h0000;
        tdata_v[1] = 16'h0000;
        fork
            begin
                // Reset values, then tready rising one edge after release.
                repeat (3) tick();
                check("rst_outs_a", {27'd0, cs_v[0], sck_v[0], mosi_v[0], rdy_v[0], ldac_v[0]}, 32'h11);
                check("rst_outs_b", {27'd0, cs_v[1], sck_v[1], mosi_v[1], rdy_v[1], ldac_v[1]}, 32'h11);
                rst = 1'b0;
                tick();
                check("rdy_after_rst", {31'd0, rdy_v[0]}, 32'd1);

                // 0x0ABC with default command bits, HALF_DIV=2.
                send(0, 16'h0ABC);
                wait_frames(0, 1);
                check("word_0abc", last_word[0], 32'h3ABC);
                check("rises_0abc", last_rises[0], 32'd16);
                check("cslow_0abc", last_cslow[0], 32'd64);

                // Upper tdata bits ignored; BUF=1, GA_N=0.
                send(1, 16'hFFFF);
                wait_frames(1, 1);
                check("word_ffff", last_word[1], 32'h5FFF);
                check("cslow_b", last_cslow[1], 32'd96);

                // tvalid pulse mid-frame must be ignored.
                send(0, 16'h0ABC);
                repeat (20) tick();
                tdata_v[0] = 16'h0555; tvalid_v[0] = 1'b1;
                tick();
                tvalid_v[0] = 1'b0; tdata_v[0] = 16'h0ABC;
                wait_frames(0, 2);
                check("word_midpulse", last_word[0], 32'h3ABC);
                repeat (100) tick();
                check("no_extra_frame", frames[0], 32'd2);

                // tvalid held high: three back-to-back frames.
                rst = 1'b1; tvalid_v[0] = 1'b1; tdata_v[0] = 16'h0001;
                repeat (2) tick();
                f0 = frames[0]; r0 = rdy_cnt[0];
                rst = 1'b0;
                for (int s = 1; s <= 3; s++) begin
                    n = 0;
                    while (rdy_v[0] !== 1'b1 && n < 2000) begin tick(); n++; end
                    check($sformatf("b2b_rdy%0d", s), {31'd0, rdy_v[0]}, 32'd1);
                    tick();
                    tdata_v[0] = 16'(s + 1);
                    if (s > 1) begin
                        // CSH cycles plus the single IDLE cycle that accepts the sample.
                        check($sformatf("b2b_gap%0d", s), last_high[0], 32'(tcsh(0) + 1));
                        check($sformatf("b2b_word%0d", s - 1), last_word[0], 32'(16'h3000 + s - 1));
                    end
                end
                tvalid_v[0] = 1'b0;
                check("b2b_rdy_cycles", rdy_cnt[0] - r0, 32'd3);
                wait_frames(0, f0 + 3);
                check("b2b_word3", last_word[0], 32'h3003);

                // Reset after the 7th sck rise aborts the frame.
                f0 = frames[0];
                send(0, 16'h0777);
                n = 0;
                while (rises[0] < 7 && n < 2000) begin tick(); n++; end
                rst = 1'b1;
                tick();
                check("abort_outs", {28'd0, cs_v[0], sck_v[0], mosi_v[0], rdy_v[0]}, 32'h8);
                check("abort_rises", last_rises[0], 32'd7);
                rst = 1'b0;
                send(0, 16'h0123);
                wait_frames(0, f0 + 2);
                check("word_after_abort", last_word[0], 32'h3123);
                check("rises_after_abort", last_rises[0], 32'd16);

`ifdef MCP4921_LDAC_EN
                // LDAC strobe on dut 1 (TCSH_CLKS=3).
                send(1, 16'h0321);
                n = 0;
                while (cs_v[1] == 1'b0 && n < 2000) begin tick(); n++; end
                k = 0;
                while (ldac_v[1] == 1'b1 && k < 50) begin tick(); k++; end
                check("ldac_delay", k, 32'd3);
                k = 0;
                while (ldac_v[1] == 1'b0 && k < 50) begin
                    check("ldac_rdy_low", {31'd0, rdy_v[1]}, 32'd0);
                    tick(); k++;
                end
                check("ldac_len", k, 32'd6);
                check("ldac_rdy_back", {31'd0, rdy_v[1]}, 32'd1);
`endif

                // Randomized traffic, including occasional resets.
                for (int c = 0; c < 3000; c++) begin
                    tick();
                    rst = ($urandom_range(0, 399) == 0);
                    for (int i = 0; i < 2; i++) begin
                        tvalid_v[i] = 1'($urandom_range(0, 1));
                        tdata_v[i]  = 16'($urandom);
                    end
                end
                rst = 1'b0;
                tvalid_v = 2'b00;
                repeat (150) tick();
                done = 1'b1;
            end
            begin
                // Cycle-by-cycle comparison of both instances against the model.
                while (!done) begin
                    @(negedge clk);
                    for (int i = 0; i < 2; i++) begin
                        check($sformatf("cycle_dut%0d", i),
                              {27'd0, cs_v[i], sck_v[i], mosi_v[i], rdy_v[i], ldac_v[i]},
                              {27'd0, expect_out(i)});
                    end
                end
            end
        join
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
